// File: rtl/hsv_core_issue_regfile_sb.sv
// Issue-stage integer register file: combinational read ports, synchronous write ports,
// hardwired x0, optional write-to-read bypass and a per-register pending-write scoreboard.
module hsv_core_issue_regfile_sb #(
   parameter int XLEN         = 32,
   parameter int NUM_REGS     = 32,
   parameter int NUM_RD_PORTS = 2,
   parameter int NUM_WR_PORTS = 2,
   parameter int BYPASS       = 1,
   localparam int AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                         clk_core,
   input  logic                         rst_n,
   input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr,
   output logic [NUM_RD_PORTS*XLEN-1:0] rd_data,
   output logic [NUM_RD_PORTS-1:0]      rd_ready,
   input  logic                         claim_valid,
   input  logic [AW-1:0]                claim_addr,
   input  logic [NUM_WR_PORTS-1:0]      wr_en,
   input  logic [NUM_WR_PORTS*AW-1:0]   wr_addr,
   input  logic [NUM_WR_PORTS*XLEN-1:0] wr_data,
   input  logic                         flush,
   output logic [NUM_REGS-1:0]          pending
);

   logic [XLEN-1:0]     regs [NUM_REGS];
   logic [NUM_REGS-1:0] pending_next;

   // x0 and out-of-range indices are never backed by state.
   function automatic logic live_addr(input logic [AW-1:0] a);
      return (a != '0) && (int'(a) < NUM_REGS);
   endfunction

   always_comb begin
      pending_next = pending;
      if (flush) begin
         pending_next = '0;
      end else begin
         for (int j = 0; j < NUM_WR_PORTS; j++) begin
            if (wr_en[j] && live_addr(wr_addr[j*AW +: AW]))
               pending_next[wr_addr[j*AW +: AW]] = 1'b0;
         end
         // A same-cycle claim names a newer producer, so it beats the clearing write.
         if (claim_valid && live_addr(claim_addr))
            pending_next[claim_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk_core or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
         pending <= '0;
      end else begin
         // Ascending order lets the highest-numbered port win an address collision.
         for (int j = 0; j < NUM_WR_PORTS; j++) begin
            if (wr_en[j] && live_addr(wr_addr[j*AW +: AW]))
               regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
         end
         pending <= pending_next;
      end
   end

   always_comb begin
      logic [AW-1:0] a;
      rd_data  = '0;
      rd_ready = '1;
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
         a = rd_addr[i*AW +: AW];
         if (live_addr(a)) begin
            rd_data[i*XLEN +: XLEN] = regs[a];
            rd_ready[i]             = !pending[a];
            // Bypass is suppressed under reset so held-reset reads stay zero.
            if (BYPASS != 0 && rst_n) begin
               for (int j = 0; j < NUM_WR_PORTS; j++) begin
                  if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
                     rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                     rd_ready[i]             = 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_hsv_core_issue_regfile_sb.sv
// Directed bench for hsv_core_issue_regfile_sb: a bypassing and a non-bypassing instance
// share every input so both read behaviours are compared against hand-computed values.
module tb_hsv_core_issue_regfile_sb;

   logic        clk_core = 1'b0;
   logic        rst_n;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data, rd_data_nb;
   logic [1:0]  rd_ready, rd_ready_nb;
   logic        claim_valid;
   logic [4:0]  claim_addr;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        flush;
   logic [31:0] pending, pending_nb;

   int errors = 0;
   int checks = 0;

   always #5 clk_core = ~clk_core;

   hsv_core_issue_regfile_sb #(.BYPASS(1)) dut (
      .clk_core(clk_core), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_ready(rd_ready), .claim_valid(claim_valid), .claim_addr(claim_addr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush), .pending(pending)
   );

   hsv_core_issue_regfile_sb #(.BYPASS(0)) dut_nb (
      .clk_core(clk_core), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
      .rd_ready(rd_ready_nb), .claim_valid(claim_valid), .claim_addr(claim_addr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush), .pending(pending_nb)
   );

   task automatic tick;
      @(posedge clk_core);
      #1;
   endtask

   task automatic idle;
      claim_valid = 1'b0;
      claim_addr  = '0;
      wr_en       = '0;
      wr_addr     = '0;
      wr_data     = '0;
      flush       = 1'b0;
   endtask

   task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
      wr_en[p]           = 1'b1;
      wr_addr[p*5 +: 5]  = a;
      wr_data[p*32 +: 32] = d;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rd_addr     = 10'($urandom);
         claim_valid = 1'($urandom);
         claim_addr  = 5'($urandom);
         wr_en       = 2'($urandom);
         wr_addr     = 10'($urandom);
         wr_data     = {$urandom, $urandom};
         flush       = 1'($urandom);
         #3;
         checks++;
         if (rd_data !== 64'h0 || rd_ready !== 2'b11) begin
            errors++;
            $display("FAIL reset_held_read: data=%h ready=%b required data=0 ready=11", rd_data, rd_ready);
         end
         @(posedge clk_core);
      end
      idle();
      #1 rst_n = 1'b1;
      tick();
      checks++;
      if (pending !== 32'h0 || pending_nb !== 32'h0) begin
         errors++;
         $display("FAIL reset_pending: got %h/%h required 0", pending, pending_nb);
      end
      for (int r = 0; r < 32; r++) begin
         rd_addr = {5'(r), 5'(r)};
         #1;
         checks++;
         if (rd_data !== 64'h0 || rd_ready !== 2'b11 || rd_data_nb !== 64'h0) begin
            errors++;
            $display("FAIL reset_read_r%0d: data=%h ready=%b required data=0 ready=11", r, rd_data, rd_ready);
         end
      end
   endtask

   task automatic test_multi_write;
      idle();
      set_wr(0, 5'd3, 32'hDEADBEEF);
      set_wr(1, 5'd15, 32'hCAFEBABE);
      tick();
      idle();
      rd_addr = {5'd15, 5'd3};
      #1;
      checks++;
      if (rd_data !== {32'hCAFEBABE, 32'hDEADBEEF} || rd_data_nb !== {32'hCAFEBABE, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL multi_write_r3_r15: got %h/%h required cafebabedeadbeef", rd_data, rd_data_nb);
      end
      set_wr(0, 5'd7, 32'h1111);
      set_wr(1, 5'd7, 32'h2222);
      tick();
      idle();
      rd_addr = {5'd3, 5'd7};
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h2222 || rd_data_nb[31:0] !== 32'h2222) begin
         errors++;
         $display("FAIL write_collision_r7: got %h/%h required 2222", rd_data[31:0], rd_data_nb[31:0]);
      end
   endtask

   task automatic test_x0_bypass;
      idle();
      set_wr(0, 5'd0, 32'hFFFFFFFF);
      rd_addr = {5'd0, 5'd0};
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_ready !== 2'b11) begin
         errors++;
         $display("FAIL x0_same_cycle: data=%h ready=%b required 0/11", rd_data, rd_ready);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_data_nb !== 64'h0) begin
         errors++;
         $display("FAIL x0_after_write: got %h/%h required 0", rd_data, rd_data_nb);
      end
      set_wr(0, 5'd5, 32'hA5A5A5A5);
      rd_addr = {5'd0, 5'd5};
      #1;
      checks++;
      if (rd_data[31:0] !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL bypass_r5: got %h required a5a5a5a5", rd_data[31:0]);
      end
      checks++;
      if (rd_data_nb[31:0] !== 32'h0) begin
         errors++;
         $display("FAIL nobypass_r5_old: got %h required 0", rd_data_nb[31:0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_data_nb[31:0] !== 32'hA5A5A5A5 || rd_data[31:0] !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL r5_next_cycle: got %h/%h required a5a5a5a5", rd_data[31:0], rd_data_nb[31:0]);
      end
      set_wr(0, 5'd5, 32'h1111);
      set_wr(1, 5'd5, 32'h2222);
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h2222 || rd_data_nb[31:0] !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL bypass_priority_r5: got %h/%h required 2222/a5a5a5a5", rd_data[31:0], rd_data_nb[31:0]);
      end
      tick();
      idle();
   endtask

   task automatic test_scoreboard;
      idle();
      claim_valid = 1'b1;
      claim_addr  = 5'd9;
      rd_addr     = {5'd0, 5'd9};
      #1;
      checks++;
      if (rd_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL claim_same_cycle_ready: got %b required 1", rd_ready[0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (pending !== 32'h0000_0200 || rd_ready !== 2'b10 || rd_ready_nb !== 2'b10) begin
         errors++;
         $display("FAIL claim_r9: pending=%h ready=%b/%b required 00000200 10/10", pending, rd_ready, rd_ready_nb);
      end
      set_wr(0, 5'd9, 32'h42);
      #1;
      checks++;
      if (rd_ready[0] !== 1'b1 || rd_data[31:0] !== 32'h42) begin
         errors++;
         $display("FAIL wb_bypass_r9: ready=%b data=%h required 1/42", rd_ready[0], rd_data[31:0]);
      end
      checks++;
      if (rd_ready_nb[0] !== 1'b0 || rd_data_nb[31:0] !== 32'h0) begin
         errors++;
         $display("FAIL wb_nobypass_r9: ready=%b data=%h required 0/0", rd_ready_nb[0], rd_data_nb[31:0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (pending !== 32'h0 || pending_nb !== 32'h0 || rd_ready_nb[0] !== 1'b1 || rd_data_nb[31:0] !== 32'h42) begin
         errors++;
         $display("FAIL wb_release_r9: pending=%h/%h data=%h required 0/0/42", pending, pending_nb, rd_data_nb[31:0]);
      end
   endtask

   task automatic test_collision;
      idle();
      claim_valid = 1'b1;
      claim_addr  = 5'd9;
      set_wr(0, 5'd9, 32'h55);
      tick();
      idle();
      rd_addr = {5'd0, 5'd9};
      #1;
      checks++;
      if (pending !== 32'h0000_0200 || rd_data[31:0] !== 32'h55 || rd_ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL claim_write_collision: pending=%h data=%h ready=%b required 00000200/55/0", pending, rd_data[31:0], rd_ready[0]);
      end
      claim_valid = 1'b1;
      claim_addr  = 5'd0;
      set_wr(1, 5'd9, 32'h56);
      tick();
      idle();
      #1;
      checks++;
      if (pending !== 32'h0 || rd_data_nb[31:0] !== 32'h56) begin
         errors++;
         $display("FAIL claim_x0_release_r9: pending=%h data=%h required 0/56", pending, rd_data_nb[31:0]);
      end
   endtask

   task automatic test_flush;
      idle();
      claim_valid = 1'b1;
      claim_addr = 5'd4;
      tick();
      claim_addr = 5'd6;
      tick();
      claim_addr = 5'd8;
      tick();
      idle();
      #1;
      checks++;
      if (pending !== 32'h0000_0150) begin
         errors++;
         $display("FAIL claims_4_6_8: got %h required 00000150", pending);
      end
      flush       = 1'b1;
      claim_valid = 1'b1;
      claim_addr  = 5'd10;
      set_wr(0, 5'd11, 32'h77);
      tick();
      idle();
      rd_addr = {5'd10, 5'd11};
      #1;
      checks++;
      if (pending !== 32'h0 || pending_nb !== 32'h0 || rd_ready_nb !== 2'b11 || rd_data_nb[31:0] !== 32'h77) begin
         errors++;
         $display("FAIL flush: pending=%h ready=%b data=%h required 0/11/77", pending, rd_ready_nb, rd_data_nb[31:0]);
      end
   endtask

   task automatic test_reset_mid;
      idle();
      set_wr(0, 5'd12, 32'hAAAA);
      tick();
      set_wr(0, 5'd13, 32'hBBBB);
      claim_valid = 1'b1;
      claim_addr  = 5'd14;
      tick();
      set_wr(1, 5'd12, 32'hCCCC);
      rd_addr = {5'd3, 5'd12};
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (pending !== 32'h0 || rd_data !== 64'h0 || rd_data_nb !== 64'h0 || rd_ready !== 2'b11) begin
         errors++;
         $display("FAIL reset_mid_burst: pending=%h data=%h/%h required 0", pending, rd_data, rd_data_nb);
      end
      tick();
      idle();
      rst_n = 1'b1;
      rd_addr = {5'd13, 5'd12};
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_data_nb !== 64'h0 || pending !== 32'h0) begin
         errors++;
         $display("FAIL after_mid_reset: data=%h pending=%h required 0/0", rd_data, pending);
      end
   endtask

   task automatic test_back_to_back;
      idle();
      rd_addr = {5'd0, 5'd20};
      for (int k = 1; k <= 3; k++) begin
         set_wr(0, 5'd20, 32'(k * 16'h1010));
         #1;
         checks++;
         if (rd_data[31:0] !== 32'(k * 16'h1010) || rd_data_nb[31:0] !== 32'((k - 1) * 16'h1010)) begin
            errors++;
            $display("FAIL back_to_back_%0d: got %h/%h required %h/%h", k, rd_data[31:0], rd_data_nb[31:0],
                     32'(k * 16'h1010), 32'((k - 1) * 16'h1010));
         end
         tick();
      end
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      rd_addr = '0;
      idle();
      test_reset();
      test_multi_write();
      test_x0_bypass();
      test_scoreboard();
      test_collision();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
